// File: rtl/oram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oram_arb_pkg: command encodings, FSM states, load/store classification   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package oram_arb_pkg;

    localparam int BECMD_W = 2;

    localparam logic [BECMD_W-1:0] BECMD_Update  = 2'd0;
    localparam logic [BECMD_W-1:0] BECMD_Append  = 2'd1;
    localparam logic [BECMD_W-1:0] BECMD_Read    = 2'd2;
    localparam logic [BECMD_W-1:0] BECMD_ReadRmv = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    // Loads (Read/ReadRmv) have the upper command bit set
    function automatic logic IsLoad(input logic [BECMD_W-1:0] cmd);
        return cmd[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter: first requester after the pointer wins (one-hot + index)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int w_cand;

    // Scan starts one past the pointer so the last owner has lowest priority
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int i = 1; i <= N; i++) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_idx            = IDX_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/oram_client_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oram_client_arbiter: round-robin sharing of one TinyORAM user port.      |
// | Optional per-client grant counters under ORAM_ARB_STATS_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module oram_client_arbiter
    import oram_arb_pkg::*;
#(
    parameter  int NumClients = 2,
    parameter  int ORAMU      = 32,
    parameter  int ORAMB      = 512,
    parameter  int FEDWidth   = 64,
    parameter  int BECMDWidth = 2,
    localparam int c_OWNER_W  = (NumClients > 1) ? $clog2(NumClients) : 1
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [NumClients*BECMDWidth-1:0] ClientCmd,
    input  logic [NumClients*ORAMU-1:0]      ClientPAddr,
    input  logic [NumClients-1:0]            ClientCmdValid,
    output logic [NumClients-1:0]            ClientCmdReady,
    input  logic [NumClients*FEDWidth-1:0]   ClientDataIn,
    input  logic [NumClients-1:0]            ClientDataInValid,
    output logic [NumClients-1:0]            ClientDataInReady,
    output logic [FEDWidth-1:0]              ClientDataOut,
    output logic [NumClients-1:0]            ClientDataOutValid,
    input  logic [NumClients-1:0]            ClientDataOutReady,
    output logic [BECMDWidth-1:0]            Cmd,
    output logic [ORAMU-1:0]                 PAddr,
    output logic                             CmdValid,
    input  logic                             CmdReady,
    output logic [FEDWidth-1:0]              DataIn,
    output logic                             DataInValid,
    input  logic                             DataInReady,
    input  logic [FEDWidth-1:0]              DataOut,
    input  logic                             DataOutValid,
    output logic                             DataOutReady,
    output logic [c_OWNER_W-1:0]             Owner,
    output logic                             Busy
`ifdef ORAM_ARB_STATS_EN
    ,
    output logic [NumClients*32-1:0]         GrantCount
`endif
);

    localparam int                   c_BEATS     = ORAMB / FEDWidth;
    localparam int                   c_BEAT_W    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_OWNER_W-1:0] c_PTR_RESET = c_OWNER_W'(NumClients - 1);
    localparam logic [c_BEAT_W-1:0]  c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);

    logic [1:0]            r_state;
    logic [c_OWNER_W-1:0]  r_owner;
    logic [c_OWNER_W-1:0]  r_ptr;
    logic [BECMDWidth-1:0] r_cmd;
    logic [ORAMU-1:0]      r_paddr;
    logic [c_BEAT_W-1:0]   r_beatCnt;

    logic [NumClients-1:0] w_grant;
    logic [c_OWNER_W-1:0]  w_grantIdx;
    logic                  w_anyReq;
    logic                  w_accept;
    logic [NumClients-1:0] w_ownerOneHot;
    logic                  w_beatFire;
    logic                  w_lastBeat;

    rr_arbiter #(
        .N     (NumClients),
        .IDX_W (c_OWNER_W)
    ) u_rr (
        .i_req   (ClientCmdValid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grantIdx),
        .o_valid (w_anyReq)
    );

    always_comb begin
        for (int i = 0; i < NumClients; i++) begin
            w_ownerOneHot[i] = (int'(r_owner) == i);
        end
    end

    // Grant is offered combinationally in IDLE; held off while reset is asserted
    assign w_accept       = (r_state == ST_IDLE) && w_anyReq && Reset;
    assign ClientCmdReady = w_accept ? w_grant : '0;

    assign CmdValid = (r_state == ST_CMD);
    assign Cmd      = r_cmd;
    assign PAddr    = r_paddr;
    assign Owner    = r_owner;
    assign Busy     = (r_state != ST_IDLE);

    assign DataIn            = ClientDataIn[int'(r_owner)*FEDWidth +: FEDWidth];
    assign DataInValid       = (r_state == ST_WDATA) && ClientDataInValid[r_owner];
    assign ClientDataInReady = ((r_state == ST_WDATA) && DataInReady) ? w_ownerOneHot : '0;

    assign ClientDataOut      = DataOut;
    assign ClientDataOutValid = ((r_state == ST_RDATA) && DataOutValid) ? w_ownerOneHot : '0;
    assign DataOutReady       = (r_state == ST_RDATA) && ClientDataOutReady[r_owner];

    assign w_beatFire = (DataInValid && DataInReady) || (DataOutValid && DataOutReady);
    assign w_lastBeat = (r_beatCnt == c_LAST_BEAT);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= c_PTR_RESET;
            r_cmd     <= '0;
            r_paddr   <= '0;
            r_beatCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= ClientCmd[int'(w_grantIdx)*BECMDWidth +: BECMDWidth];
                        r_paddr <= ClientPAddr[int'(w_grantIdx)*ORAMU +: ORAMU];
                        r_owner <= w_grantIdx;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (CmdReady) begin
                        r_beatCnt <= '0;
                        r_state   <= IsLoad(r_cmd[BECMD_W-1:0]) ? ST_RDATA : ST_WDATA;
                    end
                end
                ST_WDATA, ST_RDATA: begin
                    if (w_beatFire) begin
                        if (w_lastBeat) begin
                            r_beatCnt <= '0;
                            r_ptr     <= r_owner;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_beatCnt <= r_beatCnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ORAM_ARB_STATS_EN
    generate
        for (genvar g = 0; g < NumClients; g++) begin : g_stats
            logic [31:0] r_grantCnt;
            always_ff @(posedge Clock) begin
                if (!Reset) begin
                    r_grantCnt <= '0;
                end else if (w_accept && w_grant[g] && (r_grantCnt != 32'hFFFF_FFFF)) begin
                    r_grantCnt <= r_grantCnt + 32'd1;
                end
            end
            assign GrantCount[g*32 +: 32] = r_grantCnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_oram_client_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_oram_client_arbiter: directed scoreboard bench for the ORAM arbiter   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_oram_client_arbiter;
    import oram_arb_pkg::*;

    localparam int N = 2;

    logic            Clock = 1'b0;
    logic            Reset;
    logic [N*2-1:0]  ClientCmd;
    logic [N*32-1:0] ClientPAddr;
    logic [N-1:0]    ClientCmdValid;
    logic [N-1:0]    ClientCmdReady;
    logic [N*64-1:0] ClientDataIn;
    logic [N-1:0]    ClientDataInValid;
    logic [N-1:0]    ClientDataInReady;
    logic [63:0]     ClientDataOut;
    logic [N-1:0]    ClientDataOutValid;
    logic [N-1:0]    ClientDataOutReady;
    logic [1:0]      Cmd;
    logic [31:0]     PAddr;
    logic            CmdValid;
    logic            CmdReady;
    logic [63:0]     DataIn;
    logic            DataInValid;
    logic            DataInReady;
    logic [63:0]     DataOut;
    logic            DataOutValid;
    logic            DataOutReady;
    logic [0:0]      Owner;
    logic            Busy;
`ifdef ORAM_ARB_STATS_EN
    logic [N*32-1:0] GrantCount;
`endif

    oram_client_arbiter #(
        .NumClients (N),
        .ORAMU      (32),
        .ORAMB      (512),
        .FEDWidth   (64),
        .BECMDWidth (2)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .ClientCmd          (ClientCmd),
        .ClientPAddr        (ClientPAddr),
        .ClientCmdValid     (ClientCmdValid),
        .ClientCmdReady     (ClientCmdReady),
        .ClientDataIn       (ClientDataIn),
        .ClientDataInValid  (ClientDataInValid),
        .ClientDataInReady  (ClientDataInReady),
        .ClientDataOut      (ClientDataOut),
        .ClientDataOutValid (ClientDataOutValid),
        .ClientDataOutReady (ClientDataOutReady),
        .Cmd                (Cmd),
        .PAddr              (PAddr),
        .CmdValid           (CmdValid),
        .CmdReady           (CmdReady),
        .DataIn             (DataIn),
        .DataInValid        (DataInValid),
        .DataInReady        (DataInReady),
        .DataOut            (DataOut),
        .DataOutValid       (DataOutValid),
        .DataOutReady       (DataOutReady),
        .Owner              (Owner),
        .Busy               (Busy)
`ifdef ORAM_ARB_STATS_EN
        ,
        .GrantCount         (GrantCount)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        int          owner;
    } cmd_t;

    cmd_t        cmdQ[$];
    logic [63:0] dataQ[$];

    int          checks = 0;
    int          errors = 0;
    int          expPtr = N - 1;
    int          txnSeq = 0;
    int          win;
    logic [1:0]  reqCmd[N];
    logic [31:0] reqAddr[N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic int pickWinner(input logic [1:0] m);
        for (int i = 1; i <= N; i++) begin
            int j = (expPtr + i) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [63:0] beatData(input int c, input int i);
        return {8'hD0, 8'(c), 16'(txnSeq), 32'(i)};
    endfunction

    task automatic clearInputs();
        ClientCmd          = '0;
        ClientPAddr        = '0;
        ClientCmdValid     = '0;
        ClientDataIn       = '0;
        ClientDataInValid  = '0;
        ClientDataOutReady = '0;
        CmdReady           = 1'b0;
        DataInReady        = 1'b0;
        DataOut            = '0;
        DataOutValid       = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".cmdReady"}, ClientCmdReady, 0);
        check({tag, ".dinReady"}, ClientDataInReady, 0);
        check({tag, ".doutValid"}, ClientDataOutValid, 0);
        check({tag, ".cmdValid"}, CmdValid, 0);
        check({tag, ".dinValid"}, DataInValid, 0);
        check({tag, ".doutReady"}, DataOutReady, 0);
        check({tag, ".cmd"}, Cmd, 0);
        check({tag, ".paddr"}, PAddr, 0);
        check({tag, ".owner"}, Owner, 0);
        check({tag, ".busy"}, Busy, 0);
    endtask

    // One full transaction: request, command handshake, 8 data beats
    task automatic runTxn(input logic [1:0] mask, input int crDelay, input bit toggle,
                          input int abortAfter, output int w);
        cmd_t        got;
        cmd_t        e;
        int          beat;
        int          cyc;
        int          other;
        logic        v;
        logic        load;
        logic [63:0] d;
        txnSeq++;
        w = pickWinner(mask);
        other = 1 - w;
        for (int c = 0; c < N; c++) begin
            ClientCmd[c*2 +: 2]    = reqCmd[c];
            ClientPAddr[c*32 +: 32] = reqAddr[c];
        end
        ClientCmdValid     = mask;
        ClientDataInValid  = 2'b11;
        DataOutValid       = 1'b1;
        DataInReady        = 1'b1;
        ClientDataOutReady = 2'b11;
        CmdReady           = 1'b0;
        e.cmd = reqCmd[w]; e.addr = reqAddr[w]; e.owner = w;
        cmdQ.push_back(e);
        #1;
        check("cmdReady", ClientCmdReady, 64'(1 << w));
        check("idleBusy", Busy, 0);
        check("idleNoData", {DataInValid, DataOutReady, ClientDataInReady, ClientDataOutValid}, 0);
        tick();
        ClientCmdValid = '0;
        #1;
        got = cmdQ.pop_front();
        check("cmdValid", CmdValid, 1);
        check("cmd", Cmd, got.cmd);
        check("paddr", PAddr, got.addr);
        check("owner", Owner, got.owner);
        check("busy", Busy, 1);
        check("noGrantInCmd", ClientCmdReady, 0);
        for (int k = 0; k < crDelay; k++) begin
            tick();
            check("stallCmdValid", CmdValid, 1);
            check("stallCmd", Cmd, got.cmd);
            check("stallPAddr", PAddr, got.addr);
            check("stallNoData", {DataInValid, DataOutReady, ClientDataInReady, ClientDataOutValid}, 0);
        end
        CmdReady = 1'b1;
        tick();
        CmdReady = 1'b0;
        load = got.cmd[1];
        for (int i = 0; i < 8; i++) dataQ.push_back(beatData(w, i));
        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 200) begin
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            d = beatData(w, beat);
            if (!load) begin
                ClientDataIn[w*64 +: 64]     = d;
                ClientDataIn[other*64 +: 64] = 64'hBAD0_BAD0_BAD0_BAD0;
                ClientDataInValid[w]         = v;
                ClientDataInValid[other]     = 1'b1;
                DataInReady                  = 1'b1;
                DataOutValid                 = 1'b1;
            end else begin
                DataOut            = d;
                DataOutValid       = v;
                ClientDataOutReady = 2'b11;
                ClientDataInValid  = 2'b11;
            end
            #1;
            if (!load) begin
                check("dinValid", DataInValid, v);
                check("dinReadyOwner", ClientDataInReady, 64'(1 << w));
                check("noReadInStore", {DataOutReady, ClientDataOutValid}, 0);
                if (v) check("dinData", DataIn, dataQ.pop_front());
            end else begin
                check("doutValid", ClientDataOutValid, v ? 64'(1 << w) : 64'd0);
                check("doutReady", DataOutReady, 1);
                check("noStoreInLoad", {DataInValid, ClientDataInReady}, 0);
                if (v) check("doutData", ClientDataOut, dataQ.pop_front());
            end
            tick();
            if (v) beat++;
            cyc++;
            if (abortAfter != 0 && v && beat == abortAfter) begin
                Reset = 1'b0;
                clearInputs();
                tick();
                checkReset("abort");
                dataQ.delete();
                return;
            end
        end
        clearInputs();
        #1;
        check("doneBusy", Busy, 0);
        check("doneCmdValid", CmdValid, 0);
        check("doneNoData", {DataInValid, DataOutReady, ClientDataInReady, ClientDataOutValid}, 0);
        expPtr = w;
    endtask

    initial begin
        clearInputs();
        Reset          = 1'b0;
        ClientCmdValid = 2'b11;
        tick();
        tick();
        checkReset("reset");
`ifdef ORAM_ARB_STATS_EN
        check("grantCountReset", GrantCount, 0);
`endif
        ClientCmdValid = '0;
        Reset          = 1'b1;
        tick();

        // Client 0 Read 0x40
        reqCmd[0] = BECMD_Read; reqAddr[0] = 32'h40;
        reqCmd[1] = BECMD_Read; reqAddr[1] = 32'h0;
        runTxn(2'b01, 0, 1'b0, 0, win);

        // Simultaneous requests, four rounds
        reqCmd[0] = BECMD_ReadRmv; reqAddr[0] = 32'h100;
        reqCmd[1] = BECMD_Append;  reqAddr[1] = 32'h200;
        for (int r = 0; r < 4; r++) begin
            runTxn(2'b11, 0, 1'b0, 0, win);
        end

        // Long CmdReady stall on a store from client 0
        reqCmd[0] = BECMD_Append; reqAddr[0] = 32'h80;
        runTxn(2'b01, 20, 1'b0, 0, win);

        // Client 1 Update with gappy store data
        reqCmd[1] = BECMD_Update; reqAddr[1] = 32'h10;
        runTxn(2'b10, 0, 1'b1, 0, win);

        // Client 0 load with gappy ORAM data, leaves pointer on client 0
        reqCmd[0] = BECMD_Read; reqAddr[0] = 32'h44;
        runTxn(2'b01, 2, 1'b1, 0, win);

        // Client 1 Read aborted by reset after beat 3
        reqCmd[1] = BECMD_Read; reqAddr[1] = 32'h3C;
        runTxn(2'b10, 0, 1'b0, 3, win);
        Reset  = 1'b1;
        expPtr = N - 1;
        tick();
        reqCmd[0] = BECMD_Read;   reqAddr[0] = 32'h50;
        reqCmd[1] = BECMD_Update; reqAddr[1] = 32'h60;
        runTxn(2'b11, 0, 1'b0, 0, win);

        // Fresh reset, then 3 grants to client 0 and 2 to client 1
        Reset = 1'b0;
        tick();
        Reset  = 1'b1;
        expPtr = N - 1;
        tick();
        runTxn(2'b01, 0, 1'b0, 0, win);
        runTxn(2'b01, 0, 1'b0, 0, win);
        runTxn(2'b01, 1, 1'b0, 0, win);
        runTxn(2'b10, 0, 1'b0, 0, win);
        runTxn(2'b10, 0, 1'b0, 0, win);
`ifdef ORAM_ARB_STATS_EN
        check("grantCount", GrantCount, {32'd2, 32'd3});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
